hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MDU_LATENCY, default 4, cycles the multi-cycle multiply/divide unit occupies EX; legal range 2..32.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 idexmemrd  in  1  instruction in ID/EX is a load.
REQ-005 idexrt  in  5  load destination register in ID/EX.
REQ-006 ifidrs  in  5  rs field of the instruction in IF/ID.
REQ-007 ifidrt  in  5  rt field of the instruction in IF/ID.
REQ-008 ifidusert  in  1  the instruction in IF/ID reads rt as a source.
REQ-009 branchtaken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 mdustart  in  1  one-cycle pulse: a multiply/divide operation entered EX.
REQ-011 pcwr  out  1  PC write enable.
REQ-012 ifidwr  out  1  IF/ID register write enable.
REQ-013 ifidflush  out  1  clear IF/ID to a nop.
REQ-014 idexbubble  out  1  zero ID/EX control signals (insert bubble).
REQ-015 stalled  out  1  registered flag: the FSM is in a state other than RUN.

Function
REQ-016 FSM states RUN, LDSTALL, MDUSTALL, FLUSH; outputs are decoded combinationally from state plus inputs (Mealy).
REQ-017 Load-use hazard = idexmemrd && idexrt!=0 && (idexrt==ifidrs || (ifidusert && idexrt==ifidrt)).
REQ-018 RUN, no event: pcwr=1, ifidwr=1, ifidflush=0, idexbubble=0; remains in RUN.
REQ-019 RUN + branchtaken: same cycle ifidflush=1, idexbubble=1, pcwr=1, ifidwr=1; next state FLUSH.
REQ-020 FLUSH: outputs as RUN with no event, for exactly one cycle; then RUN (the state exists to report stalled=1 and to mask new events for that cycle).
REQ-021 RUN + mdustart (no branchtaken): same cycle pcwr=0, ifidwr=0, idexbubble=1; counter loaded with MDU_LATENCY-2; next state MDUSTALL.
REQ-022 MDUSTALL: pcwr=0, ifidwr=0, idexbubble=1; counter decrements each cycle; at counter==0, next state RUN. Total frozen cycles = MDU_LATENCY-1, including the mdustart cycle.
REQ-023 RUN + load-use hazard (no branchtaken, no mdustart): same cycle pcwr=0, ifidwr=0, idexbubble=1; next state LDSTALL.
REQ-024 LDSTALL: outputs as RUN with no event; re-evaluates the hazard; if it is still true, stalls again and stays in LDSTALL, otherwise returns to RUN.
REQ-025 Priority when events coincide: branchtaken > mdustart > load-use; losing events are dropped.
REQ-026 branchtaken and mdustart are ignored in MDUSTALL and FLUSH.
REQ-027 Register 0 never causes a stall.
REQ-028 Counter width is 5 bits and does not wrap below 0.

Reset
REQ-029 While rst_n is low: state=RUN, counter=0, stalled=0, pcwr=1, ifidwr=1, ifidflush=0, idexbubble=0; reset asserted mid-stall aborts the stall immediately.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: adds output stallcnt[31:0], which increments each cycle pcwr==0, saturates at 0xFFFFFFFF, and resets to 0; macro undefined: the port and counter are absent and all other behaviour is identical.

Structure
REQ-031 The FSM state enum, the 5-bit register-index width constant and the MDU_LATENCY default live in shared package semimips_pkg.
REQ-032 The MDU countdown is the sub-module mdu_stall_timer (load, decrement, zero flag); the FSM stays in the top module.

Verification
REQ-033 idexmemrd=1, idexrt=5, ifidrs=5 -> one cycle with pcwr=0, ifidwr=0, idexbubble=1, then RUN outputs with stalled=1 for one cycle.
REQ-034 idexmemrd=1, idexrt=0, ifidrs=0 -> no stall; pcwr remains 1.
REQ-035 idexrt=7, ifidrt=7, ifidusert=0 -> no stall; repeat with ifidusert=1 -> one-cycle stall.
REQ-036 MDU_LATENCY=4, mdustart pulse -> pcwr=0 for exactly 3 cycles, then 1; stalled=1 for 2 cycles.
REQ-037 branchtaken=1 with a coincident load-use hazard -> ifidflush=1, idexbubble=1, pcwr=1; no LDSTALL entered.
REQ-038 rst_n dropped during MDUSTALL -> outputs immediately at reset values; with HAZARD_PERF_CNT_EN defined, stallcnt reads 0.

Source files
------------

// File: rtl/semimips_pkg.sv
// Shared definitions for the semimips pipeline control blocks: register
// index width, MDU latency default, the hazard/stall FSM state encoding
// and the load-use hazard detection helper.
package semimips_pkg;

    localparam int REG_IDX_W           = 5;
    localparam int MDU_CNT_W           = 5;
    localparam int MDU_LATENCY_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LDSTALL  = 2'd1,
        ST_MDUSTALL = 2'd2,
        ST_FLUSH    = 2'd3
    } hsu_state_e;

    // A load in ID/EX feeds a source of the instruction in IF/ID; r0 never does.
    function automatic logic load_use_hazard(
        input logic                 memrd,
        input logic [REG_IDX_W-1:0] ld_rt,
        input logic [REG_IDX_W-1:0] src_rs,
        input logic [REG_IDX_W-1:0] src_rt,
        input logic                 use_rt
    );
        logic hit_s;
        hit_s = (ld_rt == src_rs) || (use_rt && (ld_rt == src_rt));
        return memrd && (ld_rt != {REG_IDX_W{1'b0}}) && hit_s;
    endfunction

endpackage : semimips_pkg

// File: rtl/mdu_stall_timer.sv
// Countdown for the multiply/divide freeze. Loaded on the mdustart cycle,
// decremented once per MDUSTALL cycle, never wraps below zero.
// zero_next flags that the current decrement brings the count to zero,
// i.e. this is the final frozen cycle.
module mdu_stall_timer
    import semimips_pkg::*;
#(
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_next
);

    logic [CNT_W-1:0] count_r;

    // Load has precedence; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Final cycle when the count is one (about to reach zero) or already zero.
    always_comb begin
        zero_next = (count_r <= {{(CNT_W-1){1'b0}}, 1'b1});
    end

endmodule : mdu_stall_timer

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: load-use stalls, multi-cycle MDU freeze
// and taken-branch flush. Outputs are Mealy-decoded from state and inputs;
// 'stalled' is registered and reports a non-RUN state.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating 32-bit count of
// cycles with the PC frozen (output stallcnt).
module hazard_stall_unit
    import semimips_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 idexmemrd,
    input  logic [REG_IDX_W-1:0] idexrt,
    input  logic [REG_IDX_W-1:0] ifidrs,
    input  logic [REG_IDX_W-1:0] ifidrt,
    input  logic                 ifidusert,
    input  logic                 branchtaken,
    input  logic                 mdustart,
    output logic                 pcwr,
    output logic                 ifidwr,
    output logic                 ifidflush,
    output logic                 idexbubble,
    output logic                 stalled
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stallcnt
`endif
);

    // MDUSTALL lasts MDU_LATENCY-2 cycles after the mdustart cycle.
    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);
    localparam logic MDU_HAS_TAIL = (MDU_LATENCY > 2) ? 1'b1 : 1'b0;

    hsu_state_e state_r;
    hsu_state_e state_next_s;
    logic       stalled_r;
    logic       hazard_s;
    logic       pcwr_s;
    logic       ifidwr_s;
    logic       flush_s;
    logic       bubble_s;
    logic       tmr_load_s;
    logic       tmr_dec_s;
    logic       tmr_zero_next_s;

    mdu_stall_timer #(
        .CNT_W     (MDU_CNT_W)
    ) u_mdu_stall_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load_s),
        .dec       (tmr_dec_s),
        .load_val  (MDU_LOAD),
        .zero_next (tmr_zero_next_s)
    );

    // Load-use detection on the current ID/EX and IF/ID fields.
    always_comb begin
        hazard_s = load_use_hazard(idexmemrd, idexrt, ifidrs, ifidrt, ifidusert);
    end

    // Next-state and Mealy output decode; priority branch > mdu > load-use.
    always_comb begin
        state_next_s = state_r;
        pcwr_s       = 1'b1;
        ifidwr_s     = 1'b1;
        flush_s      = 1'b0;
        bubble_s     = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_dec_s    = 1'b0;
        case (state_r)
            ST_MDUSTALL: begin
                pcwr_s    = 1'b0;
                ifidwr_s  = 1'b0;
                bubble_s  = 1'b1;
                tmr_dec_s = 1'b1;
                if (tmr_zero_next_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_MDUSTALL;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_RUN;
            end
            ST_RUN, ST_LDSTALL: begin
                if (branchtaken) begin
                    flush_s      = 1'b1;
                    bubble_s     = 1'b1;
                    state_next_s = ST_FLUSH;
                end else if (mdustart) begin
                    pcwr_s     = 1'b0;
                    ifidwr_s   = 1'b0;
                    bubble_s   = 1'b1;
                    tmr_load_s = 1'b1;
                    if (MDU_HAS_TAIL) begin
                        state_next_s = ST_MDUSTALL;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (hazard_s) begin
                    pcwr_s       = 1'b0;
                    ifidwr_s     = 1'b0;
                    bubble_s     = 1'b1;
                    state_next_s = ST_LDSTALL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Reset forces the run-mode outputs regardless of state and inputs.
    always_comb begin
        if (!rst_n) begin
            pcwr       = 1'b1;
            ifidwr     = 1'b1;
            ifidflush  = 1'b0;
            idexbubble = 1'b0;
        end else begin
            pcwr       = pcwr_s;
            ifidwr     = ifidwr_s;
            ifidflush  = flush_s;
            idexbubble = bubble_s;
        end
    end

    // FSM state and the registered stalled flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            stalled_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            stalled_r <= (state_next_s != ST_RUN);
        end
    end

    assign stalled = stalled_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallcnt_r;

    // Saturating count of cycles with the PC write disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallcnt_r <= 32'd0;
        end else if (!pcwr_s && (stallcnt_r != 32'hFFFF_FFFF)) begin
            stallcnt_r <= stallcnt_r + 32'd1;
        end else begin
            stallcnt_r <= stallcnt_r;
        end
    end

    assign stallcnt = stallcnt_r;
`endif

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_stall_unit;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idexmemrd;
    logic [4:0] idexrt;
    logic [4:0] ifidrs;
    logic [4:0] ifidrt;
    logic       ifidusert;
    logic       branchtaken;
    logic       mdustart;
    logic       pcwr;
    logic       ifidwr;
    logic       ifidflush;
    logic       idexbubble;
    logic       stalled;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallcnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_mdu_left = 0;   // remaining frozen cycles after an MDU start
    bit          m_mask     = 1'b0; // cycle after a taken branch
    bit          m_ld       = 1'b0; // last cycle was a load-use stall
    bit          m_stalled  = 1'b0; // registered stalled expectation
    logic [31:0] m_cnt      = 32'd0;

    // Observed counters for the directed MDU check
    int low_cnt;
    int stl_cnt;

    hazard_stall_unit #(.MDU_LATENCY(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .idexmemrd  (idexmemrd),
        .idexrt     (idexrt),
        .ifidrs     (ifidrs),
        .ifidrt     (ifidrt),
        .ifidusert  (ifidusert),
        .branchtaken(branchtaken),
        .mdustart   (mdustart),
        .pcwr       (pcwr),
        .ifidwr     (ifidwr),
        .ifidflush  (ifidflush),
        .idexbubble (idexbubble),
        .stalled    (stalled)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallcnt   (stallcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive at the falling edge, check, advance the model.
    task automatic step(input logic rst, input logic br, input logic ms,
                        input logic memrd, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic usert);
        bit e_pcwr, e_ifidwr, e_flush, e_bubble, e_stalled, haz;
        @(negedge clk);
        rst_n = rst; branchtaken = br; mdustart = ms; idexmemrd = memrd;
        idexrt = xrt; ifidrs = rs; ifidrt = rt; ifidusert = usert;
        #1;
        e_pcwr = 1'b1; e_ifidwr = 1'b1; e_flush = 1'b0; e_bubble = 1'b0;
        haz = memrd && (xrt != 5'd0) && ((xrt == rs) || (usert && (xrt == rt)));
        if (!rst) begin
            m_mdu_left = 0; m_mask = 1'b0; m_ld = 1'b0; m_stalled = 1'b0;
            m_cnt = 32'd0;
        end
        e_stalled = m_stalled;
        chk("pcwr", {31'd0, pcwr}, {31'd0, e_pcwr_f(rst, haz, br, ms)});
        if (rst) begin
            if (m_mdu_left > 0) begin
                e_pcwr = 1'b0; e_ifidwr = 1'b0; e_bubble = 1'b1;
                m_mdu_left--; m_ld = 1'b0;
            end else if (m_mask) begin
                m_mask = 1'b0; m_ld = 1'b0;
            end else if (br) begin
                e_flush = 1'b1; e_bubble = 1'b1; m_mask = 1'b1; m_ld = 1'b0;
            end else if (ms) begin
                e_pcwr = 1'b0; e_ifidwr = 1'b0; e_bubble = 1'b1;
                m_mdu_left = L - 2; m_ld = 1'b0;
            end else if (haz) begin
                e_pcwr = 1'b0; e_ifidwr = 1'b0; e_bubble = 1'b1; m_ld = 1'b1;
            end else begin
                m_ld = 1'b0;
            end
        end
        chk("ifidwr", {31'd0, ifidwr}, {31'd0, e_ifidwr});
        chk("ifidflush", {31'd0, ifidflush}, {31'd0, e_flush});
        chk("idexbubble", {31'd0, idexbubble}, {31'd0, e_bubble});
        chk("stalled", {31'd0, stalled}, {31'd0, e_stalled});
`ifdef HAZARD_PERF_CNT_EN
        chk("stallcnt", stallcnt, m_cnt);
        if (rst && !e_pcwr && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
`endif
        if (rst) m_stalled = (m_mdu_left > 0) || m_mask || m_ld;
        if (pcwr === 1'b0) low_cnt++;
        if (stalled === 1'b1) stl_cnt++;
    endtask

    // Expected pcwr from the model state before it advances.
    function automatic bit e_pcwr_f(input logic rst, input bit haz, input logic br, input logic ms);
        if (!rst) return 1'b1;
        if (m_mdu_left > 0) return 1'b0;
        if (m_mask) return 1'b1;
        if (br) return 1'b1;
        if (ms) return 1'b0;
        return !haz;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; branchtaken = 1'b0; mdustart = 1'b0; idexmemrd = 1'b0;
        idexrt = 5'd0; ifidrs = 5'd0; ifidrt = 5'd0; ifidusert = 1'b0;

        // Reset state, with a hazard pattern on the inputs
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle(2);

        // Load-use on rs: one stall cycle, then RUN outputs with stalled=1
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0);
        idle(1);

        // Register 0 never stalls
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        idle(1);

        // rt match only counts when rt is a source
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1);
        idle(2);

        // MDU start: three frozen cycles, stalled for two
        low_cnt = 0; stl_cnt = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle(5);
        chk("mdu_frozen_cycles", low_cnt, 32'd3);
        chk("mdu_stalled_cycles", stl_cnt, 32'd2);

        // Branch wins over a coincident load-use hazard; events masked after
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        idle(2);

        // mdustart beats load-use; hazards ignored during the freeze
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);

        // Reset mid-freeze aborts immediately
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
        idle(3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_hazard_stall_unit
